ws2812_frame_feeder: RTL and testbench

Pixel-frame source that sits directly upstream of the ws2812 serial driver. Holds one frame of NUM_LEDS 24-bit pixels written by the host, and streams them to the driver on a start command over the driver's rgb_data / send_n / new_data_req interface. Reorders host {R,G,B} into wire-order {G,R,B}. Every rgb_data update is timed to land exactly on a driver pixel boundary.

---
 rtl/ws2812_frame_feeder.sv | 199 +++++++++++++++++++
 tb/tb_ws2812_frame_feeder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_feeder.sv
// Frame buffer and pixel streamer feeding a ws2812 serial driver, reordering {R,G,B} to wire-order {G,R,B}.
// Optional global brightness scaling is compiled in with the WS2812_BRIGHTNESS_EN macro.
module ws2812_frame_feeder #(
  parameter int NUM_LEDS   = 8,
  parameter int BIT_CYCLES = 61,
  localparam int LED_BITS     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int PIXEL_CYCLES = 24 * BIT_CYCLES,
  localparam int CNT_BITS     = $clog2(PIXEL_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [LED_BITS-1:0] wr_addr,
  input  logic [23:0]         wr_data,
  input  logic                start,
  output logic                busy,
  output logic                frame_done,
  input  logic                new_data_req,
  output logic [23:0]         rgb_data,
  output logic                send_n
`ifdef WS2812_BRIGHTNESS_EN
  ,
  input  logic [7:0]          brightness
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_REQ = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_STAGE = CNT_BITS'(2);
  localparam logic [CNT_BITS-1:0] CNT_LAST  = CNT_BITS'(PIXEL_CYCLES - 1);
  localparam logic [LED_BITS-1:0] IDX_ZERO  = LED_BITS'(0);
  localparam logic [LED_BITS-1:0] IDX_ONE   = LED_BITS'(1);
  localparam logic [LED_BITS-1:0] LAST_IDX  = LED_BITS'(NUM_LEDS - 1);
  localparam logic [LED_BITS:0]   ADDR_LIM  = (LED_BITS + 1)'(NUM_LEDS);

  function automatic logic [23:0] reorder(input logic [23:0] px);
    return {px[15:8], px[23:16], px[7:0]};
  endfunction

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  logic [23:0]         mem_r [NUM_LEDS];
  logic [23:0]         q_r;
  logic                wr_ok_s;
  logic                rd_en_s;
  logic [LED_BITS-1:0] rd_addr_s;
  logic [23:0]         fetch_px_s;

  state_t              state_r, state_nxt;
  logic [LED_BITS-1:0] idx_r, idx_nxt;
  logic [CNT_BITS-1:0] cnt_r, cnt_nxt;
  logic [23:0]         staging_r, staging_nxt;
  logic [23:0]         rgb_data_r, rgb_nxt;
  logic                send_n_r, send_n_nxt;
  logic                busy_r, busy_nxt;
  logic                frame_done_r, frame_done_nxt;

  assign wr_ok_s = ({1'b0, wr_addr} < ADDR_LIM);

`ifdef WS2812_BRIGHTNESS_EN
  assign fetch_px_s = reorder({scale_ch(q_r[23:16], brightness),
                               scale_ch(q_r[15:8],  brightness),
                               scale_ch(q_r[7:0],   brightness)});
`else
  assign fetch_px_s = reorder(q_r);
`endif

  // Pixel RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; a same-address write in this cycle is not yet visible.
  always_ff @(posedge clk) begin
    if (rd_en_s) begin
      q_r <= mem_r[rd_addr_s];
    end
  end

  // Control state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= IDX_ZERO;
      cnt_r        <= {CNT_BITS{1'b0}};
      staging_r    <= 24'd0;
      rgb_data_r   <= 24'd0;
      send_n_r     <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      idx_r        <= idx_nxt;
      cnt_r        <= cnt_nxt;
      staging_r    <= staging_nxt;
      rgb_data_r   <= rgb_nxt;
      send_n_r     <= send_n_nxt;
      busy_r       <= busy_nxt;
      frame_done_r <= frame_done_nxt;
    end
  end

  // Next-state logic; rgb_data only changes at the last cycle of a driver pixel.
  always_comb begin
    state_nxt      = state_r;
    idx_nxt        = idx_r;
    cnt_nxt        = cnt_r;
    staging_nxt    = staging_r;
    rgb_nxt        = rgb_data_r;
    send_n_nxt     = send_n_r;
    busy_nxt       = busy_r;
    frame_done_nxt = 1'b0;
    rd_en_s        = 1'b0;
    rd_addr_s      = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          busy_nxt  = 1'b1;
          rd_en_s   = 1'b1;
          rd_addr_s = IDX_ZERO;
          state_nxt = ST_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        rgb_nxt    = fetch_px_s;
        send_n_nxt = 1'b0;
        state_nxt  = ST_WAIT_REQ;
      end
      ST_WAIT_REQ: begin
        if (new_data_req) begin
          cnt_nxt = CNT_ONE;
          if (idx_r == LAST_IDX) begin
            send_n_nxt = 1'b1;
            state_nxt  = ST_DRAIN;
          end else begin
            rd_en_s   = 1'b1;
            rd_addr_s = idx_r + IDX_ONE;
            state_nxt = ST_STREAM;
          end
        end else begin
          state_nxt = ST_WAIT_REQ;
        end
      end
      ST_STREAM: begin
        cnt_nxt = cnt_r + CNT_ONE;
        if (cnt_r == CNT_STAGE) begin
          staging_nxt = fetch_px_s;
        end else begin
          staging_nxt = staging_r;
        end
        if (cnt_r == CNT_LAST) begin
          rgb_nxt   = staging_r;
          idx_nxt   = idx_r + IDX_ONE;
          state_nxt = ST_WAIT_REQ;
        end else begin
          state_nxt = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        cnt_nxt = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          frame_done_nxt = 1'b1;
          busy_nxt       = 1'b0;
          idx_nxt        = IDX_ZERO;
          state_nxt      = ST_IDLE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        idx_nxt    = IDX_ZERO;
        send_n_nxt = 1'b1;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  assign rgb_data   = rgb_data_r;
  assign send_n     = send_n_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// Directed bench for ws2812_frame_feeder: 8-pixel and 1-pixel frames against a paced driver model.
module tb_ws2812_frame_feeder;
  localparam int PC = 1464;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, start, new_data_req;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy, frame_done, send_n;
  logic [23:0] rgb_data;

  logic        wr_en1, start1, new_data_req1;
  logic [0:0]  wr_addr1;
  logic [23:0] wr_data1;
  logic        busy1, frame_done1, send_n1;
  logic [23:0] rgb_data1;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]  brightness, brightness1;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_px [8];

  always #5 clk = ~clk;

  ws2812_frame_feeder #(.NUM_LEDS(8), .BIT_CYCLES(61)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .frame_done(frame_done), .new_data_req(new_data_req),
    .rgb_data(rgb_data), .send_n(send_n)
`ifdef WS2812_BRIGHTNESS_EN
    , .brightness(brightness)
`endif
  );

  ws2812_frame_feeder #(.NUM_LEDS(1), .BIT_CYCLES(61)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .busy(busy1), .frame_done(frame_done1), .new_data_req(new_data_req1),
    .rgb_data(rgb_data1), .send_n(send_n1)
`ifdef WS2812_BRIGHTNESS_EN
    , .brightness(brightness1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    wr_en = 1'b0; start = 1'b0; new_data_req = 1'b0; wr_addr = 3'd0; wr_data = 24'd0;
    wr_en1 = 1'b0; start1 = 1'b0; new_data_req1 = 1'b0; wr_addr1 = 1'b0; wr_data1 = 24'd0;
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'd255; brightness1 = 8'd255;
`endif
    repeat (3) tick();
    chk1("reset_send_n", send_n, 1'b1);
    chk("reset_rgb", rgb_data, 24'd0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_frame_done", frame_done, 1'b0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 24'h112233 + 24'(i);
      exp_px[i] = 24'h221133 + 24'(i);
      tick();
    end
    wr_en = 1'b0;

    // Full frame: start, then one driver pulse every PC cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_send_n_not_yet", send_n, 1'b1);
    tick();
    chk1("start_send_n_low", send_n, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("pix%0d_at_pulse", k), rgb_data, exp_px[k]);
      chk1($sformatf("pix%0d_busy", k), busy, 1'b1);
      new_data_req = 1'b1;
      tick();
      new_data_req = 1'b0;
      chk1($sformatf("pix%0d_send_n", k), send_n, (k == 7) ? 1'b1 : 1'b0);
      n = 1;
      if (k == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 2;
        chk1("start_while_busy", busy, 1'b1);
      end
      if (k == 2) begin
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'hFF0000;
        tick();
        wr_en = 1'b0;
        exp_px[5] = 24'h00FF00;
        n = 2;
      end
      repeat (PC - 1 - n) tick();
      chk($sformatf("pix%0d_window_end", k), rgb_data, exp_px[k]);
      chk1($sformatf("pix%0d_no_done", k), frame_done, 1'b0);
      if (k == 7) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk1("frame_done_pulse", frame_done, 1'b1);
    chk1("frame_done_busy", busy, 1'b0);
    chk1("frame_done_send_n", send_n, 1'b1);
    tick();
    chk1("frame_done_one_cycle", frame_done, 1'b0);
    chk1("start_in_drain_ignored", busy, 1'b0);
    chk1("idle_send_n", send_n, 1'b1);

    // Reset mid-frame at cycle 700 of pixel 3, then restart from pixel 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      new_data_req = 1'b1;
      tick();
      new_data_req = 1'b0;
      if (k < 3) begin
        repeat (PC - 1) tick();
        chk($sformatf("rst_frame_pix%0d", k + 1), rgb_data, exp_px[k + 1]);
      end else begin
        repeat (699) tick();
      end
    end
    reset_n = 1'b0;
    #1;
    chk1("midreset_send_n", send_n, 1'b1);
    chk("midreset_rgb", rgb_data, 24'd0);
    chk1("midreset_busy", busy, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_pix0", rgb_data, exp_px[0]);
    chk1("restart_send_n", send_n, 1'b0);
    new_data_req = 1'b1;
    tick();
    new_data_req = 1'b0;
    repeat (PC - 1) tick();
    chk("restart_pix1", rgb_data, exp_px[1]);

    // Single-pixel frame on the NUM_LEDS=1 instance.
    wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_data1 = 24'h0000FF;
    tick();
    wr_en1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk1("one_send_n_low", send_n1, 1'b0);
    chk("one_rgb", rgb_data1, 24'h0000FF);
    chk1("one_busy", busy1, 1'b1);
    new_data_req1 = 1'b1;
    tick();
    new_data_req1 = 1'b0;
    chk1("one_send_n_high", send_n1, 1'b1);
    chk("one_rgb_hold", rgb_data1, 24'h0000FF);
    repeat (PC - 2) tick();
    chk1("one_no_done_early", frame_done1, 1'b0);
    chk1("one_busy_before_done", busy1, 1'b1);
    tick();
    chk1("one_frame_done", frame_done1, 1'b1);
    chk1("one_busy_fall", busy1, 1'b0);

`ifdef WS2812_BRIGHTNESS_EN
    tick();
    wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_data1 = 24'hFF8040;
    brightness1 = 8'd127;
    tick();
    wr_en1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("bright_127", rgb_data1, 24'h407F20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
